// File: rtl/pulse_gen_pkg.sv
// Shared types and constant helpers for the pulse generator.
// Holds the FSM state encoding and the width function used to size the phase counter.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        res = res + 1;
        v   = v >> 1;
      end
    end
    return (res < 1) ? 1 : res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_gen_pend.sv
// Saturating count of events accepted while a pulse/gap is in progress.
// Latency: count updates on the edge after inc/dec; drop is combinational.
// Backpressure: none; an increment at saturation without a decrement is dropped.
module pulse_gen_pend #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             drop
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  assign sat  = (count == PEND_MAX);
  // A simultaneous consume frees a slot, so only an uncompensated increment can drop.
  assign drop = inc && !dec && sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!init_n) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Event-driven pulse train generator (PULSE_W high, >= GAP_W low); PULSE_GEN_OVF_EN adds sticky ovf.
// Latency: evt_in in cycle N -> pulse_out high from N+1 (N+2 with REG_EVENT=1) when idle.
// Backpressure: none; events during a pulse are queued up to 2^CNT_W-1, extras are dropped.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int REG_EVENT = 1,
  parameter int PULSE_W   = 4,
  parameter int GAP_W     = 2,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_n,
  input  logic             evt_in,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  localparam int PH_W = clog2(max2(PULSE_W, GAP_W) + 1);
  localparam logic [PH_W-1:0] PH_HIGH_LAST = PH_W'(PULSE_W - 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST  = PH_W'(GAP_W - 1);

  logic evt_eff;

  generate
    if (REG_EVENT != 0) begin : g_evt_reg
      logic evt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          evt_q <= 1'b0;
        end else if (!init_n) begin
          evt_q <= 1'b0;
        end else begin
          evt_q <= evt_in;
        end
      end
      assign evt_eff = evt_q;
    end else begin : g_evt_dir
      assign evt_eff = evt_in;
    end
  endgenerate

  state_t          state, state_nxt;
  logic [PH_W-1:0] ph, ph_nxt;
  logic            pend_inc, pend_dec, pend_sat, pend_drop;

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    pend_inc  = 1'b0;
    pend_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (evt_eff) begin
          state_nxt = HIGH;
          ph_nxt    = '0;
        end
      end
      HIGH: begin
        pend_inc = evt_eff;
        if (ph == PH_HIGH_LAST) begin
          state_nxt = GAP;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph + 1'b1;
        end
      end
      GAP: begin
        if (ph == PH_GAP_LAST) begin
          ph_nxt = '0;
          if (pend_cnt != '0) begin
            state_nxt = HIGH;
            pend_dec  = 1'b1;
            pend_inc  = evt_eff;
          end else if (evt_eff) begin
            // Nothing queued: the arriving event is consumed directly, never counted.
            state_nxt = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pend_inc = evt_eff;
          ph_nxt   = ph + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ph_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= '0;
      pulse_out <= 1'b0;
    end else if (!init_n) begin
      state     <= IDLE;
      ph        <= '0;
      pulse_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      pulse_out <= (state_nxt == HIGH);
    end
  end

  assign busy = (state != IDLE);

  pulse_gen_pend #(
    .CNT_W(CNT_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .init_n(init_n),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .count (pend_cnt),
    .sat   (pend_sat),
    .drop  (pend_drop)
  );

`ifdef PULSE_GEN_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!init_n) begin
      ovf_q <= 1'b0;
    end else if (pend_drop) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;

  logic unused_pend;
  assign unused_pend = pend_sat;
`else
  assign ovf = 1'b0;

  logic unused_pend;
  assign unused_pend = pend_sat ^ pend_drop;
`endif

endmodule
